instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: ADDR_W, default 8, width of the instruction-memory word address.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: start  input  1  one-cycle pulse that begins a programming run.
REQ-005 Port: base_addr  input  ADDR_W  first write address, captured on start.
REQ-006 Port: len  input  8  number of legal words to emit, captured on start.
REQ-007 Port: in_valid  input  1  instruction fields valid.
REQ-008 Port: in_ready  output  1  encoder accepts fields this cycle.
REQ-009 Port: op_sel  input  5  mnemonic code: 0 add, 1 sub, 2 and, 3 or, 4 nor, 5 xor, 6 slt, 7 sll, 8 srl, 9 lw, 10 sw, 11 j, 12 jr, 13 beq, 14 bne, 15 addi, 16 subi, 17 ori; 18-31 illegal.
REQ-010 Port: rs, rt, rd, shamt  input  5 each  register and shift fields.
REQ-011 Port: imm  input  26  immediate; low 16 bits for I-type, all 26 bits for j.
REQ-012 Port: out_valid  output  1  out_word/out_addr valid.
REQ-013 Port: out_ready  input  1  memory-side sink accepts the word.
REQ-014 Port: out_word  output  32  encoded instruction.
REQ-015 Port: out_addr  output  ADDR_W  word address for out_word.
REQ-016 Port: busy  output  1  high in RUN.
REQ-017 Port: done  output  1  high in DONE.
REQ-018 Port: err_illegal  output  1  sticky; an illegal op_sel was accepted during the current run.

Function
REQ-019 Encoding SHALL produce: R-type op=000000 with funct add 100000, sub 100010, and 100100, or 100101, nor 100111, xor 100110, slt 101010 (shamt field 0); sll 000000, srl 000010 (rs field 0, shamt used); lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, subi 001001, ori 001101 as op|rs|rt|imm[15:0]; j 000010 as op|imm[25:0]; jr 011111 as op|rs|21'b0.
REQ-020 States SHALL be IDLE, RUN, DONE; reset enters IDLE.
REQ-021 IDLE/DONE: in_ready=0; start with len!=0 -> RUN, capturing base_addr and len, clearing err_illegal; start with len==0 -> DONE, clearing err_illegal.
REQ-022 start in RUN SHALL be ignored.
REQ-023 RUN: in_ready = (remaining>0) and (!out_valid or out_ready); transfer occurs when in_valid and in_ready are both high.
REQ-024 Legal transfer SHALL load out_word and out_addr=current address and set out_valid on the next edge (latency 1 cycle), then increment the address and decrement remaining.
REQ-025 Illegal transfer SHALL be consumed, set err_illegal, and change neither address, remaining, nor the output register.
REQ-026 Output register SHALL hold out_word/out_addr stable while out_valid=1 and out_ready=0; out_valid clears on handshake unless reloaded in the same cycle.
REQ-027 Address SHALL wrap modulo 2^ADDR_W.
REQ-028 RUN -> DONE SHALL occur on the edge where remaining==0 and the output register is empty or being drained in that cycle.
REQ-029 busy and done SHALL be registered state decodes, mutually exclusive.

Reset
REQ-030 Reset assertion SHALL immediately force IDLE, out_valid=0, in_ready=0, busy=0, done=0, err_illegal=0, out_word=0, out_addr=0, remaining=0, address=0, regardless of activity mid-run; pending words are discarded.
REQ-031 After reset release, no output activity SHALL occur until a start pulse.

Verification
REQ-032 start base=0x10 len=1; add rd=3 rs=1 rt=2, out_ready=1 -> out_word 0x00221820 at out_addr 0x10 one cycle after transfer; done=1 the following cycle.
REQ-033 len=3: addi rt=5 rs=0 imm=0xFFFF, sll rd=4 rt=2 shamt=3, j imm=0x40 -> 0x2005FFFF, 0x000220C0, 0x08000040 at consecutive addresses.
REQ-034 len=2 with op_sel 20 between two legal words -> err_illegal=1, exactly two words emitted at consecutive addresses, then DONE.
REQ-035 out_ready low for 3 cycles with out_valid=1 -> out_word/out_addr stable, in_ready=0, no word lost or duplicated.
REQ-036 ADDR_W=8, base=0xFF, len=2 -> out_addr 0xFF then 0x00.
REQ-037 reset asserted mid-RUN with out_valid=1 -> out_valid and busy drop without a clock edge; state IDLE after release; start with len=0 -> done=1 next cycle, no output.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction encoder: turns decoded instruction fields into 32-bit words and
// streams them to sequential instruction-memory addresses for one programming run.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [25:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic              err_illegal
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        remaining;
    logic              legal;
    logic [31:0]       enc_word;
    logic              xfer;
    logic              drain;

    // Combinational encoder; legal=0 for the unassigned op codes.
    always_comb begin
        legal    = 1'b1;
        enc_word = 32'h0;
        case (op_sel)
            5'd0:  enc_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
            5'd1:  enc_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100010};
            5'd2:  enc_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100100};
            5'd3:  enc_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100101};
            5'd4:  enc_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100111};
            5'd5:  enc_word = {6'b000000, rs, rt, rd, 5'd0, 6'b100110};
            5'd6:  enc_word = {6'b000000, rs, rt, rd, 5'd0, 6'b101010};
            5'd7:  enc_word = {6'b000000, 5'd0, rt, rd, shamt, 6'b000000};
            5'd8:  enc_word = {6'b000000, 5'd0, rt, rd, shamt, 6'b000010};
            5'd9:  enc_word = {6'b100011, rs, rt, imm[15:0]};
            5'd10: enc_word = {6'b101011, rs, rt, imm[15:0]};
            5'd11: enc_word = {6'b000010, imm};
            5'd12: enc_word = {6'b011111, rs, 21'd0};
            5'd13: enc_word = {6'b000100, rs, rt, imm[15:0]};
            5'd14: enc_word = {6'b000101, rs, rt, imm[15:0]};
            5'd15: enc_word = {6'b001000, rs, rt, imm[15:0]};
            5'd16: enc_word = {6'b001001, rs, rt, imm[15:0]};
            5'd17: enc_word = {6'b001101, rs, rt, imm[15:0]};
            default: legal = 1'b0;
        endcase
    end

    assign drain    = out_valid && out_ready;
    assign in_ready = busy && (remaining != 8'd0) && (!out_valid || out_ready);
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_illegal <= 1'b0;
            addr        <= '0;
            remaining   <= 8'd0;
            out_valid   <= 1'b0;
            out_word    <= 32'h0;
            out_addr    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_illegal <= 1'b0;
                        if (len != 8'd0) begin
                            state     <= RUN;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            addr      <= base_addr;
                            remaining <= len;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // A legal load takes priority over clearing on drain, so a
                    // same-cycle drain+reload keeps out_valid high.
                    if (xfer && legal) begin
                        out_word  <= enc_word;
                        out_addr  <= addr;
                        out_valid <= 1'b1;
                        addr      <= addr + ADDR_W'(1);
                        remaining <= remaining - 8'd1;
                    end else if (drain) begin
                        out_valid <= 1'b0;
                    end
                    if (xfer && !legal)
                        err_illegal <= 1'b1;
                    if (remaining == 8'd0 && (!out_valid || out_ready)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: each task drives one scenario and checks
// outputs against hand-encoded words; a negedge monitor records emitted words.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  base_addr;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op_sel, rs, rt, rd, shamt;
    logic [25:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [7:0]  out_addr;
    logic        busy, done, err_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] q_word[$];
    logic [7:0]  q_addr[$];

    instr_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .op_sel(op_sel), .rs(rs), .rt(rt),
        .rd(rd), .shamt(shamt), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_addr(out_addr), .busy(busy), .done(done),
        .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    // Inputs only change #1 after a rising edge, so negedge sees the upcoming handshake.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            q_word.push_back(out_word);
            q_addr.push_back(out_addr);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] b, input logic [7:0] l);
        start = 1'b1; base_addr = b; len = l;
        tick();
        start = 1'b0;
    endtask

    task automatic drive(input logic [4:0] op, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [4:0] sh, input logic [25:0] im,
                         output bit ok);
        op_sel = op; rs = s; rt = t; rd = d; shamt = sh; imm = im;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && !done; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; base_addr = 8'h0; len = 8'h0; in_valid = 1'b0;
        op_sel = 5'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; shamt = 5'd0; imm = 26'd0;
        out_ready = 1'b1;
        #2;
        n_checks++; if ({out_valid, in_ready, busy, done, err_illegal} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b required 00000", {out_valid, in_ready, busy, done, err_illegal}); end
        n_checks++; if ({out_word, out_addr} !== 40'h0) begin n_fail++; $display("FAIL reset_regs: got %h required 0", {out_word, out_addr}); end
        tick(); tick();
        reset = 1'b1;
        in_valid = 1'b1;
        repeat (4) tick();
        in_valid = 1'b0;
        n_checks++; if ({out_valid, in_ready, busy, done} !== 4'b0) begin n_fail++; $display("FAIL idle_quiet: got %b required 0000", {out_valid, in_ready, busy, done}); end
        n_checks++; if (q_word.size() !== 0) begin n_fail++; $display("FAIL idle_no_words: got %0d required 0", q_word.size()); end
    endtask

    task automatic test_single_add();
        bit ok;
        q_word.delete(); q_addr.delete();
        out_ready = 1'b1;
        do_start(8'h10, 8'd1);
        n_checks++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL single_busy: got %b required 10", {busy, done}); end
        drive(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_xfer: timeout"); end
        n_checks++; if (out_valid !== 1'b1 || out_word !== 32'h00221820 || out_addr !== 8'h10) begin n_fail++; $display("FAIL single_out: got v=%b %h @%h required v=1 00221820 @10", out_valid, out_word, out_addr); end
        tick();
        n_checks++; if ({busy, done, out_valid} !== 3'b010) begin n_fail++; $display("FAIL single_done: got %b required 010", {busy, done, out_valid}); end
    endtask

    task automatic test_three();
        bit ok0, ok1, ok2;
        q_word.delete(); q_addr.delete();
        out_ready = 1'b1;
        do_start(8'h20, 8'd3);
        drive(5'd15, 5'd0, 5'd5, 5'd0, 5'd0, 26'h000FFFF, ok0);
        drive(5'd7,  5'd0, 5'd2, 5'd4, 5'd3, 26'd0, ok1);
        drive(5'd11, 5'd0, 5'd0, 5'd0, 5'd0, 26'h0000040, ok2);
        wait_done();
        n_checks++; if (!(ok0 && ok1 && ok2) || done !== 1'b1) begin n_fail++; $display("FAIL three_done: ok=%b%b%b done=%b required 1111", ok0, ok1, ok2, done); end
        n_checks++; if (q_word.size() !== 3) begin n_fail++; $display("FAIL three_count: got %0d required 3", q_word.size()); end
        else begin
            n_checks++; if (q_word[0] !== 32'h2005FFFF || q_addr[0] !== 8'h20) begin n_fail++; $display("FAIL three_addi: got %h @%h required 2005ffff @20", q_word[0], q_addr[0]); end
            n_checks++; if (q_word[1] !== 32'h000220C0 || q_addr[1] !== 8'h21) begin n_fail++; $display("FAIL three_sll: got %h @%h required 000220c0 @21", q_word[1], q_addr[1]); end
            n_checks++; if (q_word[2] !== 32'h08000040 || q_addr[2] !== 8'h22) begin n_fail++; $display("FAIL three_j: got %h @%h required 08000040 @22", q_word[2], q_addr[2]); end
        end
    endtask

    task automatic test_illegal();
        bit ok0, ok1, ok2;
        q_word.delete(); q_addr.delete();
        out_ready = 1'b1;
        do_start(8'h30, 8'd2);
        drive(5'd1, 5'd2, 5'd3, 5'd1, 5'd0, 26'd0, ok0);
        n_checks++; if (err_illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_pre: got %b required 0", err_illegal); end
        drive(5'd20, 5'd9, 5'd9, 5'd9, 5'd9, 26'h3FFFFFF, ok1);
        n_checks++; if (err_illegal !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL illegal_flag: got err=%b busy=%b required 1 1", err_illegal, busy); end
        drive(5'd3, 5'd4, 5'd5, 5'd7, 5'd0, 26'd0, ok2);
        wait_done();
        n_checks++; if (!(ok0 && ok1 && ok2) || done !== 1'b1 || err_illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_done: ok=%b%b%b done=%b err=%b required 11111", ok0, ok1, ok2, done, err_illegal); end
        n_checks++; if (q_word.size() !== 2) begin n_fail++; $display("FAIL illegal_count: got %0d required 2", q_word.size()); end
        else begin
            n_checks++; if (q_word[0] !== 32'h00430822 || q_addr[0] !== 8'h30) begin n_fail++; $display("FAIL illegal_w0: got %h @%h required 00430822 @30", q_word[0], q_addr[0]); end
            n_checks++; if (q_word[1] !== 32'h00853825 || q_addr[1] !== 8'h31) begin n_fail++; $display("FAIL illegal_w1: got %h @%h required 00853825 @31", q_word[1], q_addr[1]); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        q_word.delete(); q_addr.delete();
        out_ready = 1'b0;
        do_start(8'h40, 8'd2);
        n_checks++; if (err_illegal !== 1'b0) begin n_fail++; $display("FAIL bp_err_cleared: got %b required 0", err_illegal); end
        drive(5'd9, 5'd1, 5'd2, 5'd0, 5'd0, 26'h0000004, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_xfer: timeout"); end
        op_sel = 5'd10; rs = 5'd3; rt = 5'd4; imm = 26'h0000008; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_word !== 32'h8C220004 || out_addr !== 8'h40) begin n_fail++; $display("FAIL bp_hold%0d: got rdy=%b v=%b %h @%h required 0 1 8c220004 @40", i, in_ready, out_valid, out_word, out_addr); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready: got %b required 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_word !== 32'hAC640008 || out_addr !== 8'h41) begin n_fail++; $display("FAIL bp_reload: got v=%b %h @%h required 1 ac640008 @41", out_valid, out_word, out_addr); end
        wait_done();
        n_checks++; if (q_word.size() !== 2) begin n_fail++; $display("FAIL bp_count: got %0d required 2", q_word.size()); end
        else begin
            n_checks++; if (q_word[0] !== 32'h8C220004 || q_word[1] !== 32'hAC640008 || q_addr[1] !== 8'h41) begin n_fail++; $display("FAIL bp_words: got %h %h @%h required 8c220004 ac640008 @41", q_word[0], q_word[1], q_addr[1]); end
        end
    endtask

    task automatic test_wrap();
        bit ok0, ok1;
        q_word.delete(); q_addr.delete();
        out_ready = 1'b1;
        do_start(8'hFF, 8'd2);
        drive(5'd2, 5'd1, 5'd1, 5'd1, 5'd0, 26'd0, ok0);
        drive(5'd5, 5'd2, 5'd2, 5'd2, 5'd0, 26'd0, ok1);
        wait_done();
        n_checks++; if (!(ok0 && ok1) || q_word.size() !== 2) begin n_fail++; $display("FAIL wrap_count: ok=%b%b got %0d required 2", ok0, ok1, q_word.size()); end
        else begin
            n_checks++; if (q_addr[0] !== 8'hFF || q_addr[1] !== 8'h00) begin n_fail++; $display("FAIL wrap_addr: got %h %h required ff 00", q_addr[0], q_addr[1]); end
            n_checks++; if (q_word[0] !== 32'h00210824 || q_word[1] !== 32'h00421026) begin n_fail++; $display("FAIL wrap_words: got %h %h required 00210824 00421026", q_word[0], q_word[1]); end
        end
    endtask

    task automatic test_reset_midrun();
        bit ok;
        q_word.delete(); q_addr.delete();
        out_ready = 1'b0;
        do_start(8'h50, 8'd3);
        drive(5'd6, 5'd1, 5'd1, 5'd1, 5'd0, 26'd0, ok);
        n_checks++; if (!ok || out_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_pre: ok=%b v=%b busy=%b required 1 1 1", ok, out_valid, busy); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if ({out_valid, busy, in_ready, done} !== 4'b0 || out_word !== 32'h0 || out_addr !== 8'h0) begin n_fail++; $display("FAIL mid_async: got %b %h @%h required 0000 0 @0", {out_valid, busy, in_ready, done}, out_word, out_addr); end
        tick();
        reset = 1'b1;
        tick();
        n_checks++; if ({out_valid, busy, done} !== 3'b0) begin n_fail++; $display("FAIL mid_idle: got %b required 000", {out_valid, busy, done}); end
        out_ready = 1'b1;
        do_start(8'h60, 8'd0);
        n_checks++; if ({busy, done, err_illegal} !== 3'b010) begin n_fail++; $display("FAIL zero_len: got %b required 010", {busy, done, err_illegal}); end
        repeat (3) tick();
        n_checks++; if (q_word.size() !== 0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL zero_len_quiet: got %0d words v=%b required 0 0", q_word.size(), out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_three();
        test_illegal();
        test_backpressure();
        test_wrap();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
